// File: rtl/sink_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sink_checker: NoC traffic sink. Accepts every valid beat, checks routing    |
// | and per-source sequence continuity, and paces ready_out with a stall timer. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module sink_checker #(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NODE         = 15,
  parameter int NUM_PKTS     = 1000,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [31:0]      rx_count,
  output logic [15:0]      seq_err_count,
  output logic [15:0]      dest_err_count,
  output logic [7:0]       last_src_id,
  output logic             error,
  output logic             done
);

  localparam int CW = WIDTH - 2*N_ADDR_WIDTH - 8;

  logic [N_ADDR_WIDTH-1:0] w_src;
  logic [N_ADDR_WIDTH-1:0] w_dst;
  logic [7:0]              w_id;
  logic [CW-1:0]           w_seq;
  logic [CW-1:0]           w_exp;
  logic                    w_dest_bad;
  logic                    w_seq_bad;
  logic [31:0]             rx_count_d;

  logic [CW-1:0]           exp_q [N];
  logic [31:0]             rx_count_q;
  logic [15:0]             seq_err_q;
  logic [15:0]             dest_err_q;
  logic [7:0]              last_id_q;
  logic                    error_q;
  logic                    done_q;

  assign w_src = data_in[WIDTH-1 -: N_ADDR_WIDTH];
  assign w_dst = data_in[WIDTH-1-N_ADDR_WIDTH -: N_ADDR_WIDTH];
  assign w_id  = data_in[WIDTH-1-2*N_ADDR_WIDTH -: 8];
  assign w_seq = data_in[CW-1:0];

  // Table lookup is only meaningful for legal sources; illegal ones never reach the compare.
  assign w_dest_bad = (w_dst != N_ADDR_WIDTH'(NODE)) || (32'(w_src) >= 32'(N));
  assign w_exp      = w_dest_bad ? '0 : exp_q[w_src];
  assign w_seq_bad  = !w_dest_bad && (w_seq != w_exp);
  assign rx_count_d = rx_count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_count_q <= '0;
      seq_err_q  <= '0;
      dest_err_q <= '0;
      last_id_q  <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < N; i++) exp_q[i] <= CW'(1);
    end else if (valid_in) begin
      rx_count_q <= rx_count_d;
      last_id_q  <= w_id;
      if (w_dest_bad) begin
        if (dest_err_q != 16'hFFFF) dest_err_q <= dest_err_q + 16'd1;
      end else begin
        if (w_seq_bad && seq_err_q != 16'hFFFF) seq_err_q <= seq_err_q + 16'd1;
        exp_q[w_src] <= w_seq + CW'(1);
      end
      if (w_dest_bad || w_seq_bad) error_q <= 1'b1;
      if (rx_count_d == 32'(NUM_PKTS)) done_q <= 1'b1;
    end
  end

  generate
    if (STALL_PERIOD == 0) begin : g_stall_off
      assign ready_out = 1'b1;
    end else begin : g_stall_on
      logic [31:0] stall_cnt_q;
      logic        ready_q;
      // Free-running pacing counter; ready is low for the first STALL_CYCLES counts of each period.
      always_ff @(posedge clk) begin
        if (rst) begin
          stall_cnt_q <= '0;
          ready_q     <= 1'b1;
        end else begin
          ready_q     <= !(stall_cnt_q < 32'(STALL_CYCLES));
          stall_cnt_q <= (stall_cnt_q == 32'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + 32'd1;
        end
      end
      assign ready_out = ready_q;
    end
  endgenerate

  assign rx_count       = rx_count_q;
  assign seq_err_count  = seq_err_q;
  assign dest_err_count = dest_err_q;
  assign last_src_id    = last_id_q;
  assign error          = error_q;
  assign done           = done_q;

endmodule
`default_nettype wire

// File: doc/sink_checker.md
Name: sink_checker

Overview:
- Traffic sink and checker for the NoC test harness. It is the receiving end of the traffic source.
- Attaches to one router output port. Drives flow control back into the NoC.
- Decodes each received flit as {src node, dest node, source ID, sequence counter}.
- Checks that each flit was delivered to this node, and checks per-source in-order, gap-free delivery.
- Exposes counters, error flags and a done flag to the testbench.

Parameters:
- WIDTH, 32, flit data width.
- N, 16, number of NoC nodes.
- N_ADDR_WIDTH, $clog2(N), router address width.
- NODE, 15, index of the router this sink is attached to (N_ADDR_WIDTH bits).
- NUM_PKTS, 1000, total accepted flits after which done asserts.
- STALL_PERIOD, 0, ready_out pattern period in cycles; 0 means ready_out is always 1.
- STALL_CYCLES, 0, cycles ready_out is low per period; must be less than STALL_PERIOD.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in  in  WIDTH  received flit
- valid_in  in  1  flit valid
- ready_out  out  1  flow control to the NoC
- rx_count  out  32  accepted flit count
- seq_err_count  out  16  sequence errors, saturating
- dest_err_count  out  16  misrouted or illegal-source flits, saturating
- last_src_id  out  8  ID field of the most recently accepted flit
- error  out  1  sticky; set once any error has occurred
- done  out  1  sticky; rx_count >= NUM_PKTS

Behaviour:
- Field decode, with CW = WIDTH-2*N_ADDR_WIDTH-8 and CW >= 1:
  - src = data_in[WIDTH-1 -: N_ADDR_WIDTH]
  - dst = next N_ADDR_WIDTH bits down
  - id = next 8 bits
  - seq = data_in[CW-1:0]
- Reset (synchronous, highest priority):
  - All outputs go to 0, except ready_out = 1.
  - Stall counter = 0.
  - All N expected-sequence entries = 1.
  - Reset mid-traffic discards all state; valid_in is ignored in the reset cycle.
- Acceptance:
  - A flit is accepted on every rising edge with valid_in = 1 and rst = 0, regardless of ready_out.
  - The source responds to ready one cycle late, so one beat may arrive after ready_out falls. It must be accepted without error.
- ready_out:
  - Registered. Driven by a mod-STALL_PERIOD cycle counter.
  - ready_out = 0 while counter < STALL_CYCLES, else 1.
  - The counter free-runs after reset and is not affected by traffic.
  - Example: STALL_PERIOD = 4, STALL_CYCLES = 1 gives the pattern 1,0,1,1,1,0,1,1,... from the first cycle after reset (counter 0 -> ready_out 0 registered one cycle later).
- Per accepted flit (all updates take effect at the same edge; outputs show them the next cycle):
  - rx_count += 1, wrapping at 2^32.
  - last_src_id = id.
  - If dst != NODE or src >= N: dest_err_count += 1, saturating at 16'hFFFF. No sequence check; table unchanged.
  - Otherwise compare seq with exp[src]:
    - Mismatch: seq_err_count += 1, saturating.
    - In both cases, resynchronise: exp[src] = seq + 1 mod 2^CW.
  - Wrap: seq = 2^CW-1 sets expected 0; a following 0 is correct.
  - A single flit can cause at most one error increment.
- error: set on any increment of either error counter; cleared only by reset.
- done:
  - Set at the edge where rx_count becomes NUM_PKTS; sticky until reset.
  - Flits after done are still accepted, counted and checked.
- Table storage: N x CW bits of flops or distributed RAM. Read-modify-write completes in one cycle; back-to-back flits from the same src must check correctly.
- No combinational path from data_in or valid_in to ready_out.

Test Plan:
- Reset, STALL_PERIOD = 0; src 3 sends seq 1..20 to NODE 15 back-to-back -> ready_out stays 1, rx_count = 20, both error counters 0, error = 0.
- Drop seq 5 from src 3 (send 1,2,3,4,6,7) -> seq_err_count = 1, error = 1; 7 is not flagged (resync after 6).
- Interleave src 2 and src 7, each 1..50, with CW = 8 and seq wrapping 255 -> 0 on src 2 -> no errors; rx_count = 100 plus the extra wrap flits.
- Flit with dst = 4 at NODE = 15 -> dest_err_count = 1, seq_err_count = 0; exp[src] unchanged (the next correct flit passes).
- STALL_PERIOD = 4, STALL_CYCLES = 1; a valid beat arrives one cycle after ready_out falls -> accepted with no error; ready_out pattern matches the spec'd sequence.
- NUM_PKTS = 10; send 12 flits, assert rst at flit 11 -> done rises with flit 10, clears on reset; all counters 0, ready_out = 1 after reset; seq 1 is then accepted cleanly.
